// File: rtl/bongo_pkg.sv
// Shared types and helpers for the DK bongo poll scheduler.
package bongo_pkg;

    // Poll sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } bongo_state_e;

    // Controller slot indices on the shared transceiver.
    localparam logic BONGO_P0 = 1'b0;
    localparam logic BONGO_P1 = 1'b1;

    // Drum bits to player controls: [1] = left (bits 3,1), [0] = right (bits 2,0).
    function automatic logic [1:0] bongo_map(input logic [3:0] b);
        return {b[3] | b[1], b[2] | b[0]};
    endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Counter-based one-cycle strobe every PERIOD clocks; not a divided clock.
module poll_tick_gen #(
    parameter int PERIOD = 25_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;

    // Free-running modulo-PERIOD counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/bongo_poll_scheduler.sv
// Alternating poll sequencer for two DK bongo controllers on one transceiver.
// Issues one transaction per slot tick, times out silent controllers, tracks
// connection status and publishes registered drum controls per player.
module bongo_poll_scheduler
    import bongo_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int POLL_HZ        = 1000,
    parameter int TIMEOUT_CYCLES = 50_000,
    parameter int MAX_MISSES     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       xcvr_start,
    output logic       xcvr_sel,
    input  logic       xcvr_busy,
    input  logic       xcvr_done,
    input  logic       xcvr_err,
    input  logic [3:0] xcvr_buttons,
    output logic [1:0] controls0,
    output logic [1:0] controls1,
    output logic [1:0] connected,
    output logic       overrun
);

    localparam int SLOT_PERIOD = CLK_HZ / (2 * POLL_HZ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MW = $clog2(MAX_MISSES + 1);
    localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_CYCLES);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISSES);

    bongo_state_e  state_q;
    logic          slot_q;
    logic          pending_q;
    logic          overrun_q;
    logic          start_q;
    logic          sel_q;
    logic [TW-1:0] to_q;
    logic          ok_q;
    logic [3:0]    btn_q;
    logic          tick;
    logic          issue_go;
    logic [1:0]    controls_w [2];

    poll_tick_gen #(
        .PERIOD (SLOT_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign issue_go = (state_q == IDLE) && pending_q && enable && !xcvr_busy;

    // One-deep slot request; a tick landing on an unconsumed request is an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= tick | (pending_q & ~issue_go);
            if (tick && pending_q && !issue_go) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Transaction sequencer with registered start/select and outcome capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= BONGO_P0;
            start_q <= 1'b0;
            sel_q   <= BONGO_P0;
            to_q    <= '0;
            ok_q    <= 1'b0;
            btn_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue_go) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        sel_q   <= slot_q;
                        to_q    <= '0;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    to_q    <= to_q + TW'(1);
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as a response.
                    if (xcvr_done) begin
                        ok_q    <= !xcvr_err;
                        btn_q   <= xcvr_buttons;
                        state_q <= UPDATE;
                    end else if (to_q == TO_LIMIT) begin
                        ok_q    <= 1'b0;
                        state_q <= UPDATE;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                UPDATE: begin
                    slot_q  <= ~slot_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic          upd;
        logic [MW-1:0] miss_q;
        logic [MW-1:0] miss_inc;
        logic [1:0]    ctl_q;
        logic          conn_q;

        assign upd      = (state_q == UPDATE) && (slot_q == 1'(gi));
        assign miss_inc = (miss_q == MISS_LIMIT) ? MISS_LIMIT : miss_q + MW'(1);

        // Per-player status: success refreshes controls, misses count toward disconnect.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                miss_q <= '0;
                ctl_q  <= 2'b00;
                conn_q <= 1'b0;
            end else if (upd) begin
                if (ok_q) begin
                    ctl_q  <= bongo_map(btn_q);
                    conn_q <= 1'b1;
                    miss_q <= '0;
                end else begin
                    miss_q <= miss_inc;
                    if (miss_inc == MISS_LIMIT) begin
                        conn_q <= 1'b0;
                        ctl_q  <= 2'b00;
                    end
                end
            end
        end

        assign controls_w[gi] = ctl_q;
        assign connected[gi]  = conn_q;
    end

    assign xcvr_start = start_q;
    assign xcvr_sel   = sel_q;
    assign controls0  = controls_w[0];
    assign controls1  = controls_w[1];
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bongo_poll_scheduler.sv
// Directed bench for bongo_poll_scheduler with a behavioural player model
// and a scoreboard of expected control/connection states.
module tb_bongo_poll_scheduler;

    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       xcvr_busy = 1'b0;
    logic       xcvr_done = 1'b0;
    logic       xcvr_err = 1'b0;
    logic [3:0] xcvr_buttons = 4'h0;
    logic       xcvr_start;
    logic       xcvr_sel;
    logic       overrun;
    logic [1:0] controls0;
    logic [1:0] controls1;
    logic [1:0] connected;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] conn;
    } exp_t;

    exp_t       sb_q[$];
    logic       m_slot = 1'b0;
    logic [1:0] m_c0 = 2'b00;
    logic [1:0] m_c1 = 2'b00;
    logic [1:0] m_conn = 2'b00;
    int         m_miss[2] = '{0, 0};

    always #5 clk = ~clk;

    bongo_poll_scheduler #(
        .CLK_HZ         (1000),
        .POLL_HZ        (50),
        .TIMEOUT_CYCLES (8),
        .MAX_MISSES     (MAXM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .xcvr_start   (xcvr_start),
        .xcvr_sel     (xcvr_sel),
        .xcvr_busy    (xcvr_busy),
        .xcvr_done    (xcvr_done),
        .xcvr_err     (xcvr_err),
        .xcvr_buttons (xcvr_buttons),
        .controls0    (controls0),
        .controls1    (controls1),
        .connected    (connected),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (xcvr_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 16'(xcvr_start), 16'd1);
    endtask

    // kind 0: clean response, 1: response flagged err, 2: silent controller.
    // dly: cycles from the start cycle to the done cycle (8 = timeout cycle).
    task automatic txn(input int kind, input int dly, input logic [3:0] btn);
        logic       s;
        logic [1:0] nc;
        int         nm;
        exp_t       e;
        wait_start();
        if (xcvr_start !== 1'b1) return;
        chk("sel_at_start", 16'(xcvr_sel), 16'(m_slot));
        s    = m_slot;
        e.c0 = m_c0;
        e.c1 = m_c1;
        e.conn = m_conn;
        nm   = m_miss[s];
        if (kind == 0) begin
            nc = {btn[3] | btn[1], btn[2] | btn[0]};
            nm = 0;
            e.conn[s] = 1'b1;
        end else begin
            nc = s ? m_c1 : m_c0;
            if (nm < MAXM) nm++;
            if (nm == MAXM) begin
                nc = 2'b00;
                e.conn[s] = 1'b0;
            end
        end
        if (s) e.c1 = nc;
        else   e.c0 = nc;
        sb_q.push_back(e);

        @(negedge clk);
        chk("start_one_cycle", 16'(xcvr_start), 16'd0);
        repeat (dly - 1) @(negedge clk);
        chk("sel_hold", 16'(xcvr_sel), 16'(s));
        if (kind != 2) begin
            xcvr_done    = 1'b1;
            xcvr_err     = (kind == 1);
            xcvr_buttons = btn;
        end
        @(negedge clk);
        xcvr_done    = 1'b0;
        xcvr_err     = 1'b0;
        xcvr_buttons = 4'h0;
        chk("ctl_before_latency", {10'd0, controls0, controls1, connected}, {10'd0, m_c0, m_c1, m_conn});
        @(negedge clk);
        e = sb_q.pop_front();
        chk("ctl_updated", {10'd0, controls0, controls1, connected}, {10'd0, e});
        m_c0 = e.c0;
        m_c1 = e.c1;
        m_conn = e.conn;
        m_miss[s] = nm;
        m_slot = ~s;
        $display("txn slot=%0d kind=%0d btn=%b controls0=%b controls1=%b connected=%b",
                 s, kind, btn, controls0, controls1, connected);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'd0, xcvr_start, xcvr_sel, overrun, controls0, controls1, connected}, 16'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {7'd0, xcvr_start, xcvr_sel, overrun, controls0, controls1, connected}, 16'd0);

        // Basic alternation and connection bring-up.
        txn(0, 3, 4'b1000);
        chk("p0_first_controls", 16'(controls0), 16'b10);
        txn(0, 3, 4'b1000);
        chk("both_connected", 16'(connected), 16'b11);

        // Player 1 mappings; player 0 untouched.
        txn(0, 3, 4'b1000);
        txn(0, 3, 4'b0101);
        chk("p1_0101", 16'(controls1), 16'b01);
        txn(0, 3, 4'b1000);
        txn(0, 3, 4'b1111);
        chk("p1_1111", 16'(controls1), 16'b11);
        chk("p0_unaffected", 16'(controls0), 16'b10);

        // Player 0 silent three times in a row.
        for (int i = 0; i < 3; i++) begin
            txn(2, 8, 4'b0000);
            if (i < 2) chk("p0_still_connected", 16'(connected[0]), 16'd1);
            txn(0, 3, 4'b0110);
        end
        chk("p0_disconnected", 16'(connected), 16'b10);
        chk("p0_controls_cleared", 16'(controls0), 16'b00);

        // Errors then recovery; the miss counter must restart from zero.
        txn(0, 3, 4'b1000);
        txn(0, 3, 4'b0001);
        txn(1, 3, 4'b1111);
        chk("err1_hold", {12'd0, controls0, connected}, {12'd0, 2'b10, 2'b11});
        txn(0, 3, 4'b0001);
        txn(1, 3, 4'b1111);
        chk("err2_hold", {12'd0, controls0, connected}, {12'd0, 2'b10, 2'b11});
        txn(0, 3, 4'b0001);
        txn(0, 3, 4'b0100);
        chk("err_recover", 16'(controls0), 16'b01);
        txn(0, 3, 4'b0001);
        txn(1, 2, 4'b1111);
        txn(0, 3, 4'b0001);
        txn(1, 4, 4'b1111);
        chk("miss_count_reset", 16'(connected), 16'b11);
        txn(0, 3, 4'b0001);

        // Done on the very cycle the timeout count is reached.
        txn(0, 8, 4'b1010);
        chk("done_at_limit", {12'd0, controls0, connected}, {12'd0, 2'b10, 2'b11});
        txn(0, 3, 4'b0001);

        // Transceiver busy for 25 cycles.
        chk("overrun_clear", 16'(overrun), 16'd0);
        xcvr_busy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("busy_no_start", 16'(xcvr_start), 16'd0);
        end
        chk("overrun_set", 16'(overrun), 16'd1);
        xcvr_busy = 1'b0;
        txn(0, 3, 4'b0011);
        chk("overrun_sticky", 16'(overrun), 16'd1);

        // Asynchronous reset in the middle of a transaction.
        wait_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {7'd0, xcvr_start, xcvr_sel, overrun, controls0, controls1, connected}, 16'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_slot = 1'b0;
        m_c0   = 2'b00;
        m_c1   = 2'b00;
        m_conn = 2'b00;
        m_miss = '{0, 0};
        sb_q.delete();
        @(negedge clk);
        chk("after_reset_idle", {7'd0, xcvr_start, xcvr_sel, overrun, controls0, controls1, connected}, 16'd0);
        txn(0, 3, 4'b1000);
        chk("resume_after_reset", {12'd0, controls0, connected}, {12'd0, 2'b10, 2'b01});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bongo_poll_scheduler.md
# bongo_poll_scheduler

Sequences polling of two DK bongo controllers that share one single-wire transceiver. Issues poll transactions in strict alternation at a fixed rate, enforces a per-transaction timeout, tracks connection status per controller and publishes registered left/right drum controls for each player. Sits between the bongo transceiver and game logic; game logic reads only this block's outputs.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `POLL_HZ`, 1000: polls per second per controller; slot period is CLK_HZ/(2*POLL_HZ) cycles.
- `TIMEOUT_CYCLES`, 50_000: maximum cycles from start to done before a miss is declared.
- `MAX_MISSES`, 3: consecutive misses that mark a controller disconnected.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: permits new polls.
- `xcvr_start` out 1: one-cycle pulse to begin a transaction.
- `xcvr_sel` out 1: controller port for the current transaction; held stable from start through done.
- `xcvr_busy` in 1: transceiver occupied; no start issued while high.
- `xcvr_done` in 1: one-cycle pulse, transaction complete.
- `xcvr_err` in 1: qualifies done; response invalid (parity, framing).
- `xcvr_buttons` in 4: drum bits, valid with done; bits 3,1 = left drum, bits 2,0 = right drum.
- `controls0`, `controls1` out 2 each: [1] = left hit, [0] = right hit, per player.
- `connected` out 2: bit n = controller n responding.
- `overrun` out 1: sticky; a slot tick was dropped.

## Operation
- Tick generator emits a one-cycle `tick` every slot period. Each tick sets a one-deep `pending` flag. A tick arriving while `pending` is already set sets `overrun`. Only reset clears `overrun`.
- FSM states: IDLE, ISSUE, WAIT, UPDATE.
- IDLE → ISSUE when `pending & enable & !xcvr_busy`. `pending` clears on entry to ISSUE.
- ISSUE: the block asserts `xcvr_start` for exactly one cycle and drives `xcvr_sel = slot`. The timeout counter loads 0. Next state is WAIT.
- WAIT: the timeout counter increments each cycle.
  - `xcvr_done & !xcvr_err` → success.
  - `xcvr_done & xcvr_err` → miss.
  - Counter reaching TIMEOUT_CYCLES without done → miss.
  - Done and timeout in the same cycle → done wins.
  - All three outcomes go to UPDATE.
- UPDATE (one cycle):
  - On success: `controlsN[1] <= b[3]|b[1]`, `controlsN[0] <= b[2]|b[0]`, `miss[N] <= 0`, `connected[N] <= 1`.
  - On miss: `miss[N]` increments, saturating at MAX_MISSES. On reaching MAX_MISSES, `connected[N] <= 0` and `controlsN <= 2'b00`. Otherwise `controlsN` holds its last value.
  - `slot` toggles in all cases. Next state is IDLE.
- `enable` deasserted during ISSUE/WAIT: the current transaction completes normally, and no new ISSUE occurs until `enable` returns. `pending` is retained while disabled.
- `xcvr_done` in IDLE or ISSUE is ignored.
- Miss counter width is $clog2(MAX_MISSES+1). Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset (async assert, sync deassert handled upstream) sets: state IDLE, `slot` 0, `pending` 0, `overrun` 0, `xcvr_start` 0, `xcvr_sel` 0, `controls0`/`controls1` 2'b00, `connected` 2'b00, miss counters 0, tick counter 0.
- Reset mid-WAIT abandons the transaction. `xcvr_start` never glitches.
- Start latency: `xcvr_start` is high in the cycle after the IDLE cycle that sees `pending & enable & !xcvr_busy`.
- Control latency: `controlsN` and `connected` change 2 cycles after the `xcvr_done` cycle (WAIT→UPDATE, register in UPDATE).
- Timeout: a miss is declared in the cycle the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after ISSUE.
- Controllers are polled in strict alternation 0,1,0,1 regardless of outcome.

## Structure
- `bongo_pkg` holds:
  - the state enum (`IDLE`, `ISSUE`, `WAIT`, `UPDATE`);
  - the slot index constants `BONGO_P0`/`BONGO_P1`;
  - function `bongo_map(logic [3:0]) → logic [1:0]`, the drum-to-controls mapping shared with the translator path.
- One sub-module, `poll_tick_gen`: a counter-based strobe generator (parameter PERIOD, output `tick`). It is a strobe, not a divided clock, and the block runs entirely on `clk`.

## Test plan
Bench parameters: CLK_HZ=1000, POLL_HZ=50 (slot period 10), TIMEOUT_CYCLES=8, MAX_MISSES=3.
- Reset release, enable=1, transceiver answers done 3 cycles after start with buttons 4'b1000 → `xcvr_sel` sequence 0,1,0,1; `controls0`=2'b10 two cycles after done; `connected`=2'b11 after both slots.
- Player 1 buttons 4'b0101 → `controls1`=2'b01. Then 4'b1111 → 2'b11. `controls0` is unaffected.
- Player 0 never answers → miss at 8 cycles after each start. After the third consecutive miss, `connected[0]`=0 and `controls0`=2'b00. Player 1 is unaffected.
- Done with `xcvr_err`=1 twice, then a good response → `connected` stays 1 and miss counter resets to 0. `controls` hold through the error cycles.
- Done asserted in the same cycle the timeout count reaches 8 → treated as success, controls updated, no miss.
- Transceiver holds `xcvr_busy` for 25 cycles → no start while busy, `overrun`=1 after the second undelivered tick, and alternation resumes at the pending slot. Separately, asserting `rst_n`=0 mid-WAIT → all outputs 0 immediately.
